// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch controller. It sits between the PC register, the
// instruction SRAM and the IF/ID pipeline register. It issues one SRAM read
// at a time, waits for the data, and hands the instruction to IF/ID. It also
// holds the instruction while IF/ID is stalled. Flushes and chip-enable drops
// are absorbed by letting the outstanding transaction finish and discarding
// its data. A branch decided while the PC is stalled is remembered so that
// the PC register still sees it once the stall releases.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   ce_i                         PC chip enable, fetch permitted when 1
//   pc_i                         current PC
//   stall_i[5:0]                 stall vector, [0] PC hold, [1] IF/ID hold
//   flush_i                      pipeline flush (exception redirect)
//   branch_flag_i/target_i       branch decision and target from decode
//   addr_ok_i, data_ok_i         SRAM address accept / read data return
//   rdata_i                      SRAM read data
//   req_o, addr_o                SRAM request and word address
//   inst_o, inst_pc_o            fetched instruction and its PC
//   inst_valid_o                 inst_o holds a real instruction
//   stallreq_o                   IF stall request (combinational)
//   pc_branch_flag_o/target_o    branch redirect to the PC register
// ----------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        addr_ok_i,
    input  logic        data_ok_i,
    input  logic [31:0] rdata_i,
    output logic        req_o,
    output logic [31:0] addr_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        stallreq_o,
    output logic        pc_branch_flag_o,
    output logic [31:0] pc_branch_target_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic        req_r;
    logic [31:0] addr_r;
    logic [31:0] addr_nx_s;
    logic [31:0] inst_r;
    logic [31:0] inst_nx_s;
    logic [31:0] inst_pc_r;
    logic [31:0] inst_pc_nx_s;
    logic        valid_r;
    logic        valid_nx_s;
    logic        discard_r;
    logic        discard_nx_s;
    logic        br_pend_r;
    logic        br_pend_nx_s;
    logic [31:0] br_tgt_r;
    logic [31:0] br_tgt_nx_s;
    logic        drop_s;
    logic        unused_stall_s;

    // Only the PC and IF/ID hold bits matter to the fetch stage.
    assign unused_stall_s = ^stall_i[5:2];

    // Returned data is thrown away when it belongs to a stale fetch, when a
    // flush arrives together with it, or when fetching has been disabled.
    assign drop_s = discard_r | flush_i | ~ce_i;

    // Next-state and datapath logic of the fetch FSM.
    always_comb begin
        state_nx_s   = state_r;
        addr_nx_s    = addr_r;
        inst_nx_s    = inst_r;
        inst_pc_nx_s = inst_pc_r;
        valid_nx_s   = valid_r;
        discard_nx_s = discard_r;

        case (state_r)
            ST_IDLE: begin
                if (flush_i) begin
                    valid_nx_s = 1'b0;
                    inst_nx_s  = NOP_INST;
                end else begin
                    valid_nx_s = valid_r;
                end
                if (ce_i) begin
                    state_nx_s = ST_REQ;
                    addr_nx_s  = pc_i;
                    valid_nx_s = 1'b0;
                    inst_nx_s  = NOP_INST;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_REQ: begin
                // The request cannot be withdrawn; remember that its data
                // must be dropped instead.
                discard_nx_s = discard_r | flush_i | ~ce_i;
                if (flush_i) begin
                    valid_nx_s = 1'b0;
                    inst_nx_s  = NOP_INST;
                end else begin
                    valid_nx_s = valid_r;
                end
                if (addr_ok_i) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end

            ST_WAIT: begin
                if (data_ok_i) begin
                    discard_nx_s = 1'b0;
                    if (drop_s) begin
                        if (flush_i) begin
                            valid_nx_s = 1'b0;
                            inst_nx_s  = NOP_INST;
                        end else begin
                            valid_nx_s = valid_r;
                        end
                    end else begin
                        valid_nx_s   = 1'b1;
                        inst_nx_s    = rdata_i;
                        inst_pc_nx_s = addr_r;
                    end
                    if (!ce_i) begin
                        state_nx_s = ST_IDLE;
                    end else if (!drop_s && stall_i[1]) begin
                        state_nx_s = ST_HOLD;
                    end else begin
                        state_nx_s = ST_REQ;
                        addr_nx_s  = pc_i;
                    end
                end else begin
                    discard_nx_s = discard_r | flush_i | ~ce_i;
                    if (flush_i) begin
                        valid_nx_s = 1'b0;
                        inst_nx_s  = NOP_INST;
                    end else begin
                        valid_nx_s = valid_r;
                    end
                end
            end

            ST_HOLD: begin
                if (!ce_i) begin
                    state_nx_s = ST_IDLE;
                    if (flush_i) begin
                        valid_nx_s = 1'b0;
                        inst_nx_s  = NOP_INST;
                    end else begin
                        valid_nx_s = valid_r;
                    end
                end else if (flush_i || !stall_i[1]) begin
                    state_nx_s = ST_REQ;
                    addr_nx_s  = pc_i;
                    valid_nx_s = 1'b0;
                    inst_nx_s  = NOP_INST;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end

            default: begin
                state_nx_s   = ST_IDLE;
                addr_nx_s    = RESET_PC;
                inst_nx_s    = NOP_INST;
                inst_pc_nx_s = RESET_PC;
                valid_nx_s   = 1'b0;
                discard_nx_s = 1'b0;
            end
        endcase
    end

    // Pending-branch capture while the PC register is held.
    always_comb begin
        br_pend_nx_s = br_pend_r;
        br_tgt_nx_s  = br_tgt_r;
        if (flush_i) begin
            br_pend_nx_s = 1'b0;
        end else if (!stall_i[0]) begin
            br_pend_nx_s = 1'b0;
        end else if (branch_flag_i) begin
            br_pend_nx_s = 1'b1;
            br_tgt_nx_s  = branch_target_i;
        end else begin
            br_pend_nx_s = br_pend_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            req_r     <= 1'b0;
            addr_r    <= RESET_PC;
            inst_r    <= NOP_INST;
            inst_pc_r <= RESET_PC;
            valid_r   <= 1'b0;
            discard_r <= 1'b0;
            br_pend_r <= 1'b0;
            br_tgt_r  <= 32'h00000000;
        end else begin
            state_r   <= state_nx_s;
            // Request strobe is registered from the next state so it is
            // exactly high while in REQ.
            req_r     <= (state_nx_s == ST_REQ);
            addr_r    <= addr_nx_s;
            inst_r    <= inst_nx_s;
            inst_pc_r <= inst_pc_nx_s;
            valid_r   <= valid_nx_s;
            discard_r <= discard_nx_s;
            br_pend_r <= br_pend_nx_s;
            br_tgt_r  <= br_tgt_nx_s;
        end
    end

    assign req_o        = req_r;
    assign addr_o       = addr_r;
    // inst_r is loaded with NOP_INST every time valid is cleared.
    assign inst_o       = inst_r;
    assign inst_pc_o    = inst_pc_r;
    assign inst_valid_o = valid_r;

    // Stall the pipeline while a fetch is in flight, except on the cycle
    // that delivers a usable instruction.
    assign stallreq_o = (state_r == ST_REQ) |
                        ((state_r == ST_WAIT) & ~(data_ok_i & ~discard_r));

    assign pc_branch_flag_o   = branch_flag_i | br_pend_r;
    assign pc_branch_target_o = branch_flag_i ? branch_target_i : br_tgt_r;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        ce_i;
    logic [31:0] pc_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        addr_ok_i;
    logic        data_ok_i;
    logic [31:0] rdata_i;
    logic        req_o;
    logic [31:0] addr_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        stallreq_o;
    logic        pc_branch_flag_o;
    logic [31:0] pc_branch_target_o;

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .ce_i               (ce_i),
        .pc_i               (pc_i),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .branch_flag_i      (branch_flag_i),
        .branch_target_i    (branch_target_i),
        .addr_ok_i          (addr_ok_i),
        .data_ok_i          (data_ok_i),
        .rdata_i            (rdata_i),
        .req_o              (req_o),
        .addr_o             (addr_o),
        .inst_o             (inst_o),
        .inst_pc_o          (inst_pc_o),
        .inst_valid_o       (inst_valid_o),
        .stallreq_o         (stallreq_o),
        .pc_branch_flag_o   (pc_branch_flag_o),
        .pc_branch_target_o (pc_branch_target_o)
    );

    // Free-running clock, 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".req"},   32'(req_o),        32'h0);
        check_val({tag, ".addr"},  addr_o,            32'hbfc00000);
        check_val({tag, ".ipc"},   inst_pc_o,         32'hbfc00000);
        check_val({tag, ".inst"},  inst_o,            32'h00000000);
        check_val({tag, ".valid"}, 32'(inst_valid_o), 32'h0);
        check_val({tag, ".stall"}, 32'(stallreq_o),   32'h0);
        check_val({tag, ".brf"},   32'(pc_branch_flag_o), 32'h0);
    endtask

    initial begin
        rst = 1'b0; ce_i = 1'b0; pc_i = 32'hbfc00000; stall_i = 6'b000000;
        flush_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h00000000;
        addr_ok_i = 1'b0; data_ok_i = 1'b0; rdata_i = 32'h00000000;
        #2 rst = 1'b1;
        #1 check_reset_vals("rst");
        cyc(); cyc();
        rst = 1'b0;

        // Basic fetch: addr_ok on cycle 2, data_ok on cycle 4.
        ce_i = 1'b1;
        cyc();                                       // cycle 1, REQ
        check_val("c1.req",   32'(req_o),      32'h1);
        check_val("c1.addr",  addr_o,          32'hbfc00000);
        check_val("c1.stall", 32'(stallreq_o), 32'h1);
        cyc();                                       // cycle 2, REQ
        addr_ok_i = 1'b1;
        #1 check_val("c2.req", 32'(req_o),      32'h1);
        check_val("c2.stall",  32'(stallreq_o), 32'h1);
        cyc();                                       // cycle 3, WAIT
        addr_ok_i = 1'b0;
        #1 check_val("c3.req", 32'(req_o),      32'h0);
        check_val("c3.stall",  32'(stallreq_o), 32'h1);
        cyc();                                       // cycle 4, data returns
        data_ok_i = 1'b1; rdata_i = 32'h24010001; pc_i = 32'hbfc00004;
        #1 check_val("c4.stall", 32'(stallreq_o), 32'h0);
        cyc();                                       // REQ for next PC
        data_ok_i = 1'b0;
        check_val("c5.inst",  inst_o,            32'h24010001);
        check_val("c5.ipc",   inst_pc_o,         32'hbfc00000);
        check_val("c5.valid", 32'(inst_valid_o), 32'h1);
        check_val("c5.addr",  addr_o,            32'hbfc00004);
        check_val("c5.req",   32'(req_o),        32'h1);

        // Flush during WAIT: returned data is dropped.
        addr_ok_i = 1'b1;
        cyc();                                       // WAIT
        addr_ok_i = 1'b0; flush_i = 1'b1; pc_i = 32'h80000000;
        cyc();                                       // WAIT, discard set
        flush_i = 1'b0;
        check_val("fl.valid", 32'(inst_valid_o), 32'h0);
        check_val("fl.inst",  inst_o,            32'h00000000);
        data_ok_i = 1'b1; rdata_i = 32'hdeadbeef;
        #1 check_val("fl.stall", 32'(stallreq_o), 32'h1);
        cyc();                                       // REQ with new PC
        data_ok_i = 1'b0;
        check_val("fl.valid2", 32'(inst_valid_o), 32'h0);
        check_val("fl.inst2",  inst_o,            32'h00000000);
        check_val("fl.addr",   addr_o,            32'h80000000);
        check_val("fl.req",    32'(req_o),        32'h1);

        // Flush on the same cycle as data_ok.
        addr_ok_i = 1'b1;
        cyc();                                       // WAIT
        addr_ok_i = 1'b0; pc_i = 32'h80000100;
        flush_i = 1'b1; data_ok_i = 1'b1; rdata_i = 32'h11111111;
        cyc();                                       // REQ
        flush_i = 1'b0; data_ok_i = 1'b0;
        check_val("fd.req",   32'(req_o),        32'h1);
        check_val("fd.addr",  addr_o,            32'h80000100);
        check_val("fd.valid", 32'(inst_valid_o), 32'h0);
        addr_ok_i = 1'b1;
        cyc();                                       // WAIT
        addr_ok_i = 1'b0;
        data_ok_i = 1'b1; rdata_i = 32'h22222222; stall_i = 6'b000010;
        #1 check_val("fd.stall", 32'(stallreq_o), 32'h0);

        // IF/ID stall at data return: HOLD for three cycles.
        cyc();                                       // HOLD
        data_ok_i = 1'b0; pc_i = 32'h80000104;
        for (int i = 0; i < 3; i++) begin
            check_val("hd.inst",  inst_o,            32'h22222222);
            check_val("hd.ipc",   inst_pc_o,         32'h80000100);
            check_val("hd.valid", 32'(inst_valid_o), 32'h1);
            check_val("hd.req",   32'(req_o),        32'h0);
            check_val("hd.stall", 32'(stallreq_o),   32'h0);
            if (i < 2) begin
                cyc();
            end else begin
                stall_i = 6'b000000;
            end
        end
        cyc();                                       // REQ on release
        check_val("hr.req",   32'(req_o),        32'h1);
        check_val("hr.addr",  addr_o,            32'h80000104);
        check_val("hr.valid", 32'(inst_valid_o), 32'h0);
        check_val("hr.inst",  inst_o,            32'h00000000);

        // Branch while PC is stalled stays visible until the stall releases.
        stall_i = 6'b000001; branch_flag_i = 1'b1; branch_target_i = 32'hbfc00100;
        #1 check_val("br.f0", 32'(pc_branch_flag_o), 32'h1);
        check_val("br.t0", pc_branch_target_o, 32'hbfc00100);
        cyc();
        branch_flag_i = 1'b0; branch_target_i = 32'h12345678;
        #1 check_val("br.f1", 32'(pc_branch_flag_o), 32'h1);
        check_val("br.t1", pc_branch_target_o, 32'hbfc00100);
        cyc();
        check_val("br.f2", 32'(pc_branch_flag_o), 32'h1);
        check_val("br.t2", pc_branch_target_o, 32'hbfc00100);
        stall_i = 6'b000000;
        #1 check_val("br.f3", 32'(pc_branch_flag_o), 32'h1);
        cyc();
        check_val("br.f4", 32'(pc_branch_flag_o), 32'h0);

        // Reset asserted during WAIT.
        addr_ok_i = 1'b1;
        cyc();                                       // WAIT
        addr_ok_i = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals("rw");
        cyc();
        rst = 1'b0; ce_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h33333333;
        cyc();
        data_ok_i = 1'b0;
        check_val("rw.valid", 32'(inst_valid_o), 32'h0);
        check_val("rw.inst",  inst_o,            32'h00000000);
        check_val("rw.req",   32'(req_o),        32'h0);

        // Chip enable dropped mid-transaction: data dropped, back to IDLE.
        ce_i = 1'b1; pc_i = 32'hbfc00000;
        cyc();                                       // REQ
        ce_i = 1'b0; addr_ok_i = 1'b1;
        cyc();                                       // WAIT, discard set
        addr_ok_i = 1'b0;
        check_val("ce.stall", 32'(stallreq_o), 32'h1);
        data_ok_i = 1'b1; rdata_i = 32'h44444444;
        cyc();                                       // IDLE
        data_ok_i = 1'b0;
        check_val("ce.req",   32'(req_o),        32'h0);
        check_val("ce.valid", 32'(inst_valid_o), 32'h0);
        check_val("ce.inst",  inst_o,            32'h00000000);
        check_val("ce.stall2", 32'(stallreq_o),  32'h0);
        cyc();
        check_val("ce.idle",  32'(req_o),        32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
